// File: rtl/priority_irq_ctrl.sv
// rtl/priority_irq_ctrl.sv - grouped priority interrupt controller with single-presentation handshake.
// Define IRQ_EDGE_DETECT_EN for edge-captured requests; default build registers req as level.
module priority_irq_ctrl #(
  parameter int NCH  = 9,
  parameter int NGRP = 3,
  localparam int CW  = (NCH  > 1) ? $clog2(NCH)  : 1,
  localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NGRP*NCH-1:0]  req,
  input  logic                 ack,
  output logic                 irq_valid,
  output logic [GW-1:0]        irq_grp,
  output logic [CW-1:0]        irq_chan,
  output logic [NGRP-1:0]      grp_pend
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t               state;
  logic [NGRP*NCH-1:0]  pend;
  logic [NGRP*NCH-1:0]  act;
  logic [NGRP-1:0]      grp_any;
  logic [NCH-1:0]       win_row;
  logic                 win_found;
  logic [GW-1:0]        win_grp;
  logic [CW-1:0]        win_chan;

  always_comb begin
    act     = '0;
    grp_any = '0;
    for (int g = 0; g < NGRP; g++) begin
      act[g*NCH +: NCH] = pend[g*NCH +: NCH] & en;
      grp_any[g]        = |act[g*NCH +: NCH];
    end
  end

  // Descending group scan leaves the lowest active group; ascending channel scan leaves the highest channel.
  always_comb begin
    win_found = |grp_any;
    win_grp   = '0;
    win_row   = '0;
    win_chan  = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (grp_any[g]) begin
        win_grp = GW'(g);
        win_row = act[g*NCH +: NCH];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (win_row[c]) win_chan = CW'(c);
    end
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [NGRP*NCH-1:0] req_q;
  logic [NGRP*NCH-1:0] clr;

  always_comb begin
    clr = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int c = 0; c < NCH; c++) begin
        clr[g*NCH + c] = (state == PRESENT) && ack &&
                         (irq_grp == GW'(g)) && (irq_chan == CW'(c));
      end
    end
  end

  // A new edge on the bit being acknowledged outranks its clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend  <= '0;
      req_q <= '0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | (req & ~req_q);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_grp   <= '0;
      irq_chan  <= '0;
      grp_pend  <= '0;
    end else begin
      grp_pend <= grp_any;
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= PRESENT;
            irq_valid <= 1'b1;
            irq_grp   <= win_grp;
            irq_chan  <= win_chan;
          end
        end
        PRESENT: begin
          if (ack) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// tb/tb_priority_irq_ctrl.sv - randomized and directed checks of priority_irq_ctrl against a behavioural model.
module tb_priority_irq_ctrl;

  localparam int NCH  = 9;
  localparam int NGRP = 3;
  localparam int CW   = 4;
  localparam int GW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       en;
  logic [NGRP*NCH-1:0]  req;
  logic                 ack;
  logic                 irq_valid;
  logic [GW-1:0]        irq_grp;
  logic [CW-1:0]        irq_chan;
  logic [NGRP-1:0]      grp_pend;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  priority_irq_ctrl #(.NCH(NCH), .NGRP(NGRP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack),
    .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_chan(irq_chan), .grp_pend(grp_pend)
  );

  always #5 clk = ~clk;

  // Behavioural model: state advanced once per rising edge from the inputs seen at that edge.
  bit [NGRP*NCH-1:0] m_pend, m_prev, m_np;
  bit [NGRP-1:0]     m_gp;
  bit                m_valid, m_any;
  int                m_grp, m_chan, m_wg, m_wc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_gp = '0;
      m_valid = 1'b0; m_grp = 0; m_chan = 0;
    end else begin
      m_any = 1'b0; m_wg = 0; m_wc = 0;
      for (int g = 0; g < NGRP && !m_any; g++)
        for (int c = NCH - 1; c >= 0; c--)
          if (m_pend[g*NCH + c] && en[c]) begin
            m_any = 1'b1; m_wg = g; m_wc = c;
            break;
          end
      for (int g = 0; g < NGRP; g++) begin
        m_gp[g] = 1'b0;
        for (int c = 0; c < NCH; c++)
          if (m_pend[g*NCH + c] && en[c]) m_gp[g] = 1'b1;
      end
`ifdef IRQ_EDGE_DETECT_EN
      m_np = m_pend;
      if (m_valid && ack) m_np[m_grp*NCH + m_chan] = 1'b0;
      for (int i = 0; i < NGRP*NCH; i++)
        if (req[i] && !m_prev[i]) m_np[i] = 1'b1;
      m_prev = req;
`else
      m_np = req;
`endif
      m_pend = m_np;
      if (m_valid) begin
        if (ack) m_valid = 1'b0;
      end else if (m_any) begin
        m_valid = 1'b1; m_grp = m_wg; m_chan = m_wc;
      end
    end
  end

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act_v, exp_v, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model irq_valid", int'(irq_valid), int'(m_valid));
      check("model grp_pend", int'(grp_pend), int'(m_gp));
      if (m_valid) begin
        check("model irq_grp", int'(irq_grp), m_grp);
        check("model irq_chan", int'(irq_chan), m_chan);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ack = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = '1; req = '0; ack = 1'b0;
    tick(2);
    check("reset irq_valid", int'(irq_valid), 0);
    check("reset irq_grp", int'(irq_grp), 0);
    check("reset irq_chan", int'(irq_chan), 0);
    check("reset grp_pend", int'(grp_pend), 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    tick(2);

    // Group priority: g1c3 beats g2c8.
    req[1*NCH + 3] = 1'b1; req[2*NCH + 8] = 1'b1;
    tick(1);
    req = '0;
    tick(1);
    check("prio valid", int'(irq_valid), 1);
    check("prio grp", int'(irq_grp), 1);
    check("prio chan", int'(irq_chan), 3);
    check("prio grp_pend", int'(grp_pend), 3'b110);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("prio gap", int'(irq_valid), 0);
    tick(1);
`ifdef IRQ_EDGE_DETECT_EN
    check("prio second grp", int'(irq_grp), 2);
    check("prio second chan", int'(irq_chan), 8);
    ack = 1'b1; tick(1); ack = 1'b0;
`else
    check("prio level dropped", int'(irq_valid), 0);
`endif
    tick(2);

`ifdef IRQ_EDGE_DETECT_EN
    // Channel order within a group, then re-present of a colliding set/clear.
    req[2] = 1'b1; req[7] = 1'b1;
    tick(1); req = '0; tick(1);
    check("chan first", int'(irq_chan), 7);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("chan gap", int'(irq_valid), 0);
    tick(1);
    check("chan second valid", int'(irq_valid), 1);
    check("chan second", int'(irq_chan), 2);
    ack = 1'b1; tick(1); ack = 1'b0; tick(2);

    req[2*NCH + 4] = 1'b1; tick(1); req = '0; tick(1);
    req[2*NCH + 4] = 1'b1; ack = 1'b1; tick(1); req = '0; ack = 1'b0;
    check("collide gap", int'(irq_valid), 0);
    tick(1);
    check("collide valid", int'(irq_valid), 1);
    check("collide grp", int'(irq_grp), 2);
    check("collide chan", int'(irq_chan), 4);
    do_reset();
    check("abort valid", int'(irq_valid), 0);
    tick(3);
    check("abort quiet", int'(irq_valid), 0);
`else
    // Held level request is re-presented after every ack gap.
    req[1*NCH + 0] = 1'b1;
    tick(2);
    check("level valid", int'(irq_valid), 1);
    check("level grp", int'(irq_grp), 1);
    check("level chan", int'(irq_chan), 0);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("level gap", int'(irq_valid), 0);
    tick(1);
    check("level again", int'(irq_valid), 1);
    req = '0; ack = 1'b1; tick(1); ack = 1'b0;
    tick(1);
    check("level drop 1", int'(irq_valid), 0);
    tick(1);
    check("level drop 2", int'(irq_valid), 0);
`endif
    do_reset();
    tick(1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      en    = ($urandom_range(0, 3) != 0) ? '1 : NCH'($urandom);
      for (int i = 0; i < NGRP*NCH; i++)
        req[i] = ($urandom_range(0, 15) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    rst_n = 1'b1; req = '0; ack = 1'b0;
    tick(2);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
